// File: rtl/mem_stage_lsu_pkg.sv
// mem_stage_lsu_pkg: ISA constants and memory-op decode
// shared by the MEM-stage load/store unit.
package mem_stage_lsu_pkg;

  localparam int WORD   = 32;
  localparam int REG_W  = 5;
  localparam int OP_W   = 6;
  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;

  localparam logic [OP_W-1:0] OP_LB  = 6'h20;
  localparam logic [OP_W-1:0] OP_LH  = 6'h21;
  localparam logic [OP_W-1:0] OP_LW  = 6'h23;
  localparam logic [OP_W-1:0] OP_LBU = 6'h24;
  localparam logic [OP_W-1:0] OP_LHU = 6'h25;
  localparam logic [OP_W-1:0] OP_SB  = 6'h28;
  localparam logic [OP_W-1:0] OP_SH  = 6'h29;
  localparam logic [OP_W-1:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;
  typedef enum logic {IDLE, BUSY} state_e;

  typedef struct packed {
    logic  mem;
    logic  store;
    logic  uns;
    size_e size;
  } dec_t;

  function automatic dec_t decode(input logic [OP_W-1:0] op);
    dec_t d;
    d.mem   = 1'b1;
    d.store = 1'b0;
    d.uns   = 1'b0;
    d.size  = SZ_W;
    unique case (1'b1)
      (op == OP_LB):  d.size = SZ_B;
      (op == OP_LH):  d.size = SZ_H;
      (op == OP_LW):  d.size = SZ_W;
      (op == OP_LBU): begin d.size = SZ_B; d.uns = 1'b1; end
      (op == OP_LHU): begin d.size = SZ_H; d.uns = 1'b1; end
      (op == OP_SB):  begin d.size = SZ_B; d.store = 1'b1; end
      (op == OP_SH):  begin d.size = SZ_H; d.store = 1'b1; end
      (op == OP_SW):  begin d.size = SZ_W; d.store = 1'b1; end
      default:        d.mem = 1'b0;
    endcase
    return d;
  endfunction

  function automatic logic misaligned(input size_e sz, input logic [1:0] a);
    return ((sz == SZ_H) && a[0]) || ((sz == SZ_W) && (a != 2'b00));
  endfunction

endpackage

// File: rtl/mem_stage_lsu_byte_lane.sv
// mem_byte_lane: store lane enables/replication and
// load lane extract with sign or zero extension.
module mem_byte_lane
  import mem_stage_lsu_pkg::*;
(
  input  dec_t            dec,
  input  logic [1:0]      a,
  input  logic [WORD-1:0] sdata,
  input  logic [WORD-1:0] rdata,
  output logic [3:0]      be,
  output logic [WORD-1:0] wdata,
  output logic [WORD-1:0] ldata
);

  logic [BYTE_W-1:0] bsel;
  logic [HALF_W-1:0] hsel;
  logic              sgn;

  assign bsel = rdata[{a, 3'b000} +: BYTE_W];
  assign hsel = rdata[{a[1], 4'b0000} +: HALF_W];

  always_comb begin
    be    = 4'b1111;
    wdata = sdata;
    ldata = rdata;
    sgn   = 1'b0;
    unique case (dec.size)
      SZ_B: begin
        be    = 4'b0001 << a;
        wdata = {4{sdata[BYTE_W-1:0]}};
        sgn   = ~dec.uns & bsel[BYTE_W-1];
        ldata = {{(WORD-BYTE_W){sgn}}, bsel};
      end
      SZ_H: begin
        be    = a[1] ? 4'b1100 : 4'b0011;
        wdata = {2{sdata[HALF_W-1:0]}};
        sgn   = ~dec.uns & hsel[HALF_W-1];
        ldata = {{(WORD-HALF_W){sgn}}, hsel};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit with req/ack
// data port, timeout abort and registered WB outputs.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             memValid,
  input  logic [WORD-1:0]  memInstruction,
  input  logic [WORD-1:0]  memNewPC,
  input  logic [WORD-1:0]  memAluOut,
  input  logic [WORD-1:0]  memMemWriteData,
  input  logic [REG_W-1:0] memWriteReg,
  output logic             stall,
  output logic             dReq,
  output logic             dWe,
  output logic [WORD-1:0]  dAddr,
  output logic [3:0]       dBe,
  output logic [WORD-1:0]  dWData,
  input  logic             dAck,
  input  logic [WORD-1:0]  dRData,
  output logic             wbValid,
  output logic             wbRegWrite,
  output logic [REG_W-1:0] wbWriteReg,
  output logic [WORD-1:0]  wbData,
  output logic [WORD-1:0]  wbNewPC,
  output logic [WORD-1:0]  wbInstruction,
  output logic             wbMisaligned,
  output logic             wbBusErr
);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  dec_t             idec, cdec, ldec;
  logic [1:0]       ca, la;
  logic [REG_W-1:0] creg;
  logic [WORD-1:0]  cpc, cinstr;
  logic [3:0]       lbe;
  logic [WORD-1:0]  lwd, lrd;
  logic             busy, mis, issue, tmo;

  assign busy  = (state == BUSY);
  assign idec  = decode(memInstruction[31:26]);
  assign mis   = misaligned(idec.size, memAluOut[1:0]);
  assign issue = ~busy & memValid & idec.mem & ~mis;
  assign tmo   = (cnt == CNT_W'(TIMEOUT - 1));
  assign stall = busy ? ~(dAck | tmo) : issue;

  // One lane unit: issue-time store lanes in IDLE, load extract in BUSY.
  assign ldec = busy ? cdec : idec;
  assign la   = busy ? ca : memAluOut[1:0];

  mem_byte_lane u_lane (
    .dec   (ldec),
    .a     (la),
    .sdata (memMemWriteData),
    .rdata (dRData),
    .be    (lbe),
    .wdata (lwd),
    .ldata (lrd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      dReq          <= 1'b0;
      dWe           <= 1'b0;
      dAddr         <= '0;
      dBe           <= '0;
      dWData        <= '0;
      cdec          <= '0;
      ca            <= '0;
      creg          <= '0;
      cpc           <= '0;
      cinstr        <= '0;
      wbValid       <= 1'b0;
      wbRegWrite    <= 1'b0;
      wbWriteReg    <= '0;
      wbData        <= '0;
      wbNewPC       <= '0;
      wbInstruction <= '0;
      wbMisaligned  <= 1'b0;
      wbBusErr      <= 1'b0;
    end else begin
      wbValid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (issue) begin
            state  <= BUSY;
            cnt    <= '0;
            dReq   <= 1'b1;
            dWe    <= idec.store;
            dAddr  <= {memAluOut[31:2], 2'b00};
            dBe    <= lbe;
            dWData <= lwd;
            cdec   <= idec;
            ca     <= memAluOut[1:0];
            creg   <= memWriteReg;
            cpc    <= memNewPC;
            cinstr <= memInstruction;
          end else if (memValid) begin
            wbValid       <= 1'b1;
            wbRegWrite    <= ~idec.mem & (memWriteReg != '0);
            wbWriteReg    <= memWriteReg;
            wbData        <= memAluOut;
            wbNewPC       <= memNewPC;
            wbInstruction <= memInstruction;
            wbMisaligned  <= idec.mem;
            wbBusErr      <= 1'b0;
          end
        end
        BUSY: begin
          cnt <= cnt + 1'b1;
          if (dAck | tmo) begin
            state         <= IDLE;
            cnt           <= '0;
            dReq          <= 1'b0;
            dWe           <= 1'b0;
            dBe           <= '0;
            wbValid       <= 1'b1;
            wbRegWrite    <= dAck & ~cdec.store & (creg != '0);
            wbWriteReg    <= creg;
            wbData        <= (dAck & ~cdec.store) ? lrd
                                                  : {dAddr[31:2], ca};
            wbNewPC       <= cpc;
            wbInstruction <= cinstr;
            wbMisaligned  <= 1'b0;
            wbBusErr      <= ~dAck;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed and randomized checks of the
// MEM-stage LSU against a behavioural load/store model.
module tb_mem_stage_lsu;

  localparam logic [5:0] LB  = 6'h20;
  localparam logic [5:0] LH  = 6'h21;
  localparam logic [5:0] LW  = 6'h23;
  localparam logic [5:0] LBU = 6'h24;
  localparam logic [5:0] LHU = 6'h25;
  localparam logic [5:0] SB  = 6'h28;
  localparam logic [5:0] SH  = 6'h29;
  localparam logic [5:0] SW  = 6'h2B;
  localparam logic [5:0] ADD = 6'h00;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        memValid = 1'b0;
  logic [31:0] memInstruction = '0;
  logic [31:0] memNewPC = '0;
  logic [31:0] memAluOut = '0;
  logic [31:0] memMemWriteData = '0;
  logic [4:0]  memWriteReg = '0;
  logic        stall, dReq, dWe;
  logic [31:0] dAddr, dWData;
  logic [3:0]  dBe;
  logic        dAck = 1'b0;
  logic [31:0] dRData = '0;
  logic        wbValid, wbRegWrite, wbMisaligned, wbBusErr;
  logic [4:0]  wbWriteReg;
  logic [31:0] wbData, wbNewPC, wbInstruction;

  int errors = 0;
  int checks = 0;

  int          nst, nreq, unstable;
  logic        got;
  logic        o_we;
  logic [3:0]  o_be;
  logic [31:0] o_addr, o_wd;

  always #5 clk = ~clk;

  mem_stage_lsu dut (
    .clk(clk), .rst(rst), .memValid(memValid),
    .memInstruction(memInstruction), .memNewPC(memNewPC),
    .memAluOut(memAluOut), .memMemWriteData(memMemWriteData),
    .memWriteReg(memWriteReg), .stall(stall), .dReq(dReq),
    .dWe(dWe), .dAddr(dAddr), .dBe(dBe), .dWData(dWData),
    .dAck(dAck), .dRData(dRData), .wbValid(wbValid),
    .wbRegWrite(wbRegWrite), .wbWriteReg(wbWriteReg),
    .wbData(wbData), .wbNewPC(wbNewPC),
    .wbInstruction(wbInstruction), .wbMisaligned(wbMisaligned),
    .wbBusErr(wbBusErr)
  );

  function automatic logic is_mem(input logic [5:0] op);
    return op inside {LB, LH, LW, LBU, LHU, SB, SH, SW};
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return op inside {SB, SH, SW};
  endfunction

  function automatic logic is_mis(input logic [5:0] op, input logic [31:0] a);
    if (op inside {LH, LHU, SH}) return (a % 2) != 0;
    if (op inside {LW, SW}) return (a % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [5:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] r);
    logic [31:0] v;
    v = r;
    if (op == LB || op == LBU) begin
      v = (r >> (8 * (a % 4))) & 32'hFF;
      if (op == LB && v >= 128) v = v - 256;
    end else if (op == LH || op == LHU) begin
      v = (r >> (16 * ((a % 4) / 2))) & 32'hFFFF;
      if (op == LH && v >= 32768) v = v - 65536;
    end
    return v;
  endfunction

  function automatic logic [3:0] ref_be(input logic [5:0] op, input logic [31:0] a);
    if (op == SB || op == LB || op == LBU) return 4'(1 << (a % 4));
    if (op == SH || op == LH || op == LHU) return ((a % 4) >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] ref_wd(input logic [5:0] op, input logic [31:0] d);
    if (op == SB) return (d & 32'hFF) * 32'h0101_0101;
    if (op == SH) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  // Presents one instruction, answers dAck on the ackdel-th request
  // cycle (0 = never), and returns once WB has been loaded.
  task automatic run_op(input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] d, input logic [4:0] rd,
                        input logic [31:0] pc, input int ackdel,
                        input logic [31:0] rdat);
    logic st;
    memValid = 1'b1;
    memInstruction = {op, 26'h0ABCDE};
    memAluOut = a;
    memMemWriteData = d;
    memWriteReg = rd;
    memNewPC = pc;
    nst = 0; nreq = 0; unstable = 0; got = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (dReq) begin
        nreq++;
        if (nreq == 1) begin
          o_be = dBe; o_wd = dWData; o_addr = dAddr; o_we = dWe;
        end else if (dBe !== o_be || dWData !== o_wd ||
                     dAddr !== o_addr || dWe !== o_we) begin
          unstable++;
        end
        if (nreq == ackdel) begin dAck = 1'b1; dRData = rdat; end
      end
      #1;
      st = stall;
      if (st) nst++;
      @(posedge clk);
      #1;
      dAck = 1'b0;
      if (!st) begin got = 1'b1; break; end
    end
    memValid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (dReq !== 1'b0) begin errors++; $display("FAIL reset_dReq got=%b want=0", dReq); end
    checks++; if (dBe !== 4'h0 || dWe !== 1'b0) begin errors++; $display("FAIL reset_dBe_dWe got=%h/%b want=0/0", dBe, dWe); end
    checks++; if (wbValid !== 1'b0 || wbData !== 32'h0 || wbRegWrite !== 1'b0) begin errors++; $display("FAIL reset_wb got=%b/%h/%b want=0/0/0", wbValid, wbData, wbRegWrite); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b want=0", stall); end
    rst = 1'b0;
  endtask

  task automatic test_lw_latency;
    run_op(LW, 32'h100, 32'h0, 5'd7, 32'h4000, 3, 32'hDEADBEEF);
    checks++; if (nreq !== 3) begin errors++; $display("FAIL lw_dreq_cycles got=%0d want=3", nreq); end
    checks++; if (nst !== 3) begin errors++; $display("FAIL lw_stall_cycles got=%0d want=3", nst); end
    checks++; if (wbValid !== 1'b1 || wbData !== 32'hDEADBEEF || wbRegWrite !== 1'b1) begin errors++; $display("FAIL lw_wb got=%b/%h/%b want=1/deadbeef/1", wbValid, wbData, wbRegWrite); end
    checks++; if (o_addr !== 32'h100 || o_we !== 1'b0 || o_be !== 4'hF) begin errors++; $display("FAIL lw_bus got=%h/%b/%h want=100/0/f", o_addr, o_we, o_be); end
    checks++; if (wbNewPC !== 32'h4000 || wbWriteReg !== 5'd7) begin errors++; $display("FAIL lw_pass got=%h/%0d want=4000/7", wbNewPC, wbWriteReg); end
  endtask

  task automatic test_load_ext;
    run_op(LB, 32'h103, 32'h0, 5'd3, 32'h10, 1, 32'h80FFFFFF);
    checks++; if (wbData !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_sext got=%h want=ffffff80", wbData); end
    run_op(LBU, 32'h103, 32'h0, 5'd3, 32'h14, 2, 32'h80FFFFFF);
    checks++; if (wbData !== 32'h00000080) begin errors++; $display("FAIL lbu_zext got=%h want=00000080", wbData); end
    run_op(LHU, 32'h102, 32'h0, 5'd3, 32'h18, 1, 32'h80FFFFFF);
    checks++; if (wbData !== 32'h000080FF) begin errors++; $display("FAIL lhu_zext got=%h want=000080ff", wbData); end
  endtask

  task automatic test_store;
    run_op(SB, 32'h201, 32'h12345678, 5'd9, 32'h20, 2, 32'h0);
    checks++; if (o_addr !== 32'h200 || o_be !== 4'b0010 || o_wd !== 32'h78787878 || o_we !== 1'b1) begin errors++; $display("FAIL sb_bus got=%h/%b/%h/%b want=200/0010/78787878/1", o_addr, o_be, o_wd, o_we); end
    checks++; if (wbValid !== 1'b1 || wbRegWrite !== 1'b0 || unstable !== 0) begin errors++; $display("FAIL sb_wb got=%b/%b/%0d want=1/0/0", wbValid, wbRegWrite, unstable); end
  endtask

  task automatic test_misaligned;
    run_op(LH, 32'h101, 32'h0, 5'd4, 32'h30, 1, 32'h0);
    checks++; if (nreq !== 0 || nst !== 0) begin errors++; $display("FAIL mis_noreq got=%0d/%0d want=0/0", nreq, nst); end
    checks++; if (wbValid !== 1'b1 || wbMisaligned !== 1'b1 || wbRegWrite !== 1'b0) begin errors++; $display("FAIL mis_wb got=%b/%b/%b want=1/1/0", wbValid, wbMisaligned, wbRegWrite); end
  endtask

  task automatic test_timeout;
    run_op(LW, 32'h104, 32'h0, 5'd5, 32'h40, 0, 32'h0);
    checks++; if (nst !== 16 || nreq !== 16) begin errors++; $display("FAIL tmo_cycles got=%0d/%0d want=16/16", nst, nreq); end
    checks++; if (wbValid !== 1'b1 || wbBusErr !== 1'b1 || wbRegWrite !== 1'b0) begin errors++; $display("FAIL tmo_wb got=%b/%b/%b want=1/1/0", wbValid, wbBusErr, wbRegWrite); end
    checks++; if (dReq !== 1'b0) begin errors++; $display("FAIL tmo_dreq_low got=%b want=0", dReq); end
    run_op(ADD, 32'h55AA, 32'h0, 5'd6, 32'h44, 1, 32'h0);
    checks++; if (nst !== 0 || wbValid !== 1'b1 || wbData !== 32'h55AA || wbBusErr !== 1'b0) begin errors++; $display("FAIL tmo_add got=%0d/%b/%h/%b want=0/1/55aa/0", nst, wbValid, wbData, wbBusErr); end
  endtask

  task automatic test_reset_busy;
    memValid = 1'b1;
    memInstruction = {LW, 26'h0};
    memAluOut = 32'h300;
    memWriteReg = 5'd8;
    @(posedge clk); #1;
    memValid = 1'b0;
    @(posedge clk); #1;
    checks++; if (dReq !== 1'b1) begin errors++; $display("FAIL rb_busy got=%b want=1", dReq); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (dReq !== 1'b0 || wbValid !== 1'b0) begin errors++; $display("FAIL rb_reset got=%b/%b want=0/0", dReq, wbValid); end
    dAck = 1'b1; dRData = 32'hCAFEF00D;
    @(posedge clk); #1;
    dAck = 1'b0;
    checks++; if (wbValid !== 1'b0 || dReq !== 1'b0) begin errors++; $display("FAIL rb_late_ack got=%b/%b want=0/0", wbValid, dReq); end
  endtask

  task automatic test_back_to_back;
    run_op(ADD, 32'h1111, 32'h0, 5'd0, 32'h50, 1, 32'h0);
    checks++; if (wbValid !== 1'b1 || wbNewPC !== 32'h50 || wbRegWrite !== 1'b0) begin errors++; $display("FAIL b2b_add got=%b/%h/%b want=1/50/0", wbValid, wbNewPC, wbRegWrite); end
    run_op(LW, 32'h400, 32'h0, 5'd11, 32'h54, 1, 32'h01020304);
    checks++; if (wbValid !== 1'b1 || wbNewPC !== 32'h54 || wbData !== 32'h01020304) begin errors++; $display("FAIL b2b_lw got=%b/%h/%h want=1/54/01020304", wbValid, wbNewPC, wbData); end
    @(posedge clk); #1;
    checks++; if (wbValid !== 1'b0) begin errors++; $display("FAIL b2b_pulse got=%b want=0", wbValid); end
  endtask

  task automatic test_random;
    logic [5:0]  ops [10];
    logic [5:0]  op;
    logic [31:0] a, d, r, pc;
    logic [4:0]  rd;
    int          ad;
    logic        mem, mis, st;
    ops = '{LB, LH, LW, LBU, LHU, SB, SH, SW, ADD, 6'h0D};
    for (int i = 0; i < 60; i++) begin
      op = ops[$urandom_range(0, 9)];
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[0] = 1'b0;
      if ($urandom_range(0, 3) != 0) a[1] = 1'b0;
      d = $urandom; r = $urandom; pc = $urandom;
      rd = 5'($urandom_range(0, 31));
      ad = $urandom_range(1, 4);
      mem = is_mem(op); mis = is_mis(op, a); st = is_store(op);
      run_op(op, a, d, rd, pc, ad, r);
      checks++; if (wbValid !== 1'b1 || wbMisaligned !== mis || wbBusErr !== 1'b0) begin errors++; $display("FAIL rnd_flags i=%0d op=%h got=%b/%b/%b want=1/%b/0", i, op, wbValid, wbMisaligned, wbBusErr, mis); end
      checks++; if (nreq !== ((mem && !mis) ? ad : 0) || nst !== ((mem && !mis) ? ad : 0)) begin errors++; $display("FAIL rnd_timing i=%0d op=%h got=%0d/%0d ack=%0d", i, op, nreq, nst, ad); end
      checks++; if (wbRegWrite !== ((!mis && !st) && rd != 0) || wbWriteReg !== rd || wbNewPC !== pc) begin errors++; $display("FAIL rnd_wbctl i=%0d op=%h got=%b/%0d/%h want rd=%0d pc=%h", i, op, wbRegWrite, wbWriteReg, wbNewPC, rd, pc); end
      if (!mem) begin
        checks++; if (wbData !== a) begin errors++; $display("FAIL rnd_alu i=%0d got=%h want=%h", i, wbData, a); end
      end else if (!mis && !st) begin
        checks++; if (wbData !== ref_load(op, a, r)) begin errors++; $display("FAIL rnd_load i=%0d op=%h a=%h r=%h got=%h want=%h", i, op, a, r, wbData, ref_load(op, a, r)); end
      end else if (!mis) begin
        checks++; if (o_be !== ref_be(op, a) || o_wd !== ref_wd(op, d) || o_addr !== {a[31:2], 2'b00} || o_we !== 1'b1 || unstable !== 0) begin errors++; $display("FAIL rnd_store i=%0d op=%h a=%h got=%h/%h/%h/%b", i, op, a, o_be, o_wd, o_addr, o_we); end
      end
    end
  endtask

  initial begin
    test_reset;
    test_lw_latency;
    test_load_ext;
    test_store;
    test_misaligned;
    test_timeout;
    test_reset_busy;
    test_back_to_back;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
